prog_loader: RTL and testbench

Sequential front-end that sits directly upstream of `cpu`: it drives the instruction-memory external port (`addr_ext`, `wen_ext`, `ren_ext`, `wdata_ext`, `rdata_ext`) and the `enable` input. On `start` it accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive instruction-memory addresses. It can optionally read the image back and check it, then asserts `cpu_enable` for a programmed number of cycles and reports completion. It is the only master of the external instruction port during a test run.

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/loader_checksum.sv | 21 ++
 rtl/prog_loader.sv | 161 ++++++++++++++++
 tb/tb_prog_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and constants for prog_loader.
// The VERIFY state exists only when PROG_LOADER_VERIFY_EN is defined.
package prog_loader_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
`ifdef PROG_LOADER_VERIFY_EN
      S_VERIFY,
`endif
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;
   localparam int ADDR_SHIFT = 2;
   localparam int CSUM_W     = 32;
endpackage

// File: rtl/loader_checksum.sv
// loader_checksum: clearable mod-2^CSUM_W accumulator.
module loader_checksum
   import prog_loader_pkg::*;
(
   input  logic              clk,
   input  logic              arst_n,
   input  logic              clr,
   input  logic              add_en,
   input  logic [CSUM_W-1:0] operand,
   output logic [CSUM_W-1:0] sum
);
   logic [CSUM_W-1:0] sum_q, sum_d;

   always_comb sum_d = clr ? '0 : add_en ? sum_q + operand : sum_q;

   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) sum_q <= '0;
      else         sum_q <= sum_d;

   assign sum = sum_q;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams an instruction image into imem, then enables the cpu for run_cycles.
// PROG_LOADER_VERIFY_EN adds a read-back checksum pass (VERIFY) between LOAD and RUN.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int IMEM_DEPTH = 512,
   parameter int RUN_W      = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic [RUN_W-1:0] run_cycles,
   input  logic             s_valid,
   input  logic [31:0]      s_data,
   input  logic             s_last,
   output logic             s_ready,
   output logic [63:0]      addr_ext,
   output logic             wen_ext,
   output logic             ren_ext,
   output logic [31:0]      wdata_ext,
   input  logic [31:0]      rdata_ext,
   output logic             cpu_enable,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [9:0]       word_count
);
   state_t           state_q, state_d;
   logic [9:0]       wc_q, wc_d;
   logic [63:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             wen_q, wen_d, cpu_en_q, cpu_en_d, s_ready_q, s_ready_d;
   logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic             hs, clr;

   assign hs  = s_valid && s_ready_q;
   assign clr = start && (state_q inside {S_IDLE, S_DONE, S_ERR});

`ifdef PROG_LOADER_VERIFY_EN
   logic              ren_q, ren_d, rd_pend_q, rd_pend_d, last_ret;
   logic [9:0]        vidx_q, vidx_d;
   logic [CSUM_W-1:0] wr_sum, rd_sum;

   loader_checksum u_wr_sum (
      .clk(clk), .arst_n(arst_n), .clr(clr), .add_en(hs), .operand(s_data), .sum(wr_sum)
   );
   loader_checksum u_rd_sum (
      .clk(clk), .arst_n(arst_n), .clr(clr), .add_en(rd_pend_q), .operand(rdata_ext), .sum(rd_sum)
   );

   // Final read data arrives one cycle after the last ren; compare it folded into the sum.
   assign last_ret = state_q == S_VERIFY && rd_pend_q && !ren_q && vidx_q == wc_q;
   assign ren_ext  = ren_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^rdata_ext;
   assign ren_ext      = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      run_d   = run_q;
      wen_d   = hs;
`ifdef PROG_LOADER_VERIFY_EN
      ren_d     = 1'b0;
      rd_pend_d = ren_q;
      vidx_d    = vidx_q;
`endif
      if (clr) begin
         state_d = S_LOAD;
         wc_d    = '0;
         run_d   = run_cycles;
`ifdef PROG_LOADER_VERIFY_EN
         vidx_d  = '0;
`endif
      end
      if (hs) begin
         addr_d  = 64'(wc_q) << ADDR_SHIFT;
         wdata_d = s_data;
         wc_d    = (wc_q == 10'(IMEM_DEPTH)) ? wc_q : wc_q + 10'd1;
`ifdef PROG_LOADER_VERIFY_EN
         if (s_last) state_d = S_VERIFY;
`else
         if (s_last) state_d = (run_q == '0) ? S_DONE : S_RUN;
`endif
         else if (wc_q == 10'(IMEM_DEPTH - 1)) state_d = S_ERR;
      end
`ifdef PROG_LOADER_VERIFY_EN
      if (state_q == S_VERIFY) begin
         ren_d = vidx_q < wc_q;
         if (ren_d) begin
            addr_d = 64'(vidx_q) << ADDR_SHIFT;
            vidx_d = vidx_q + 10'd1;
         end
         if (last_ret)
            state_d = (rd_sum + rdata_ext != wr_sum) ? S_ERR : (run_q == '0) ? S_DONE : S_RUN;
      end
`endif
      if (state_q == S_RUN && cpu_en_q) begin
         run_d = run_q - RUN_W'(1);
         if (run_q == RUN_W'(1)) state_d = S_DONE;
      end
      // Entering RUN straight from LOAD waits one cycle so the final write never overlaps enable.
      cpu_en_d  = state_d == S_RUN && state_q != S_LOAD;
      s_ready_d = state_d == S_LOAD;
      busy_d    = !(state_d inside {S_IDLE, S_DONE, S_ERR});
      done_d    = state_d == S_DONE;
      error_d   = state_d == S_ERR;
   end

   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         state_q   <= S_IDLE;
         wc_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         run_q     <= '0;
         wen_q     <= 1'b0;
         cpu_en_q  <= 1'b0;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
         ren_q     <= 1'b0;
         rd_pend_q <= 1'b0;
         vidx_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         wc_q      <= wc_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         run_q     <= run_d;
         wen_q     <= wen_d;
         cpu_en_q  <= cpu_en_d;
         s_ready_q <= s_ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
`ifdef PROG_LOADER_VERIFY_EN
         ren_q     <= ren_d;
         rd_pend_q <= rd_pend_d;
         vidx_q    <= vidx_d;
`endif
      end

   assign s_ready    = s_ready_q;
   assign addr_ext   = addr_q;
   assign wen_ext    = wen_q;
   assign wdata_ext  = wdata_q;
   assign cpu_enable = cpu_en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign word_count = wc_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader with a behavioural instruction memory.
module tb_prog_loader;
   logic        clk = 1'b0, arst_n = 1'b0, start = 1'b0;
   logic [31:0] run_cycles = '0;
   logic        s_valid = 1'b0, s_last = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_ready, wen_ext, ren_ext, cpu_enable, busy, done, error;
   logic [63:0] addr_ext;
   logic [31:0] wdata_ext, rdata_ext = '0;
   logic [9:0]  word_count;

   int          checks = 0, errors = 0, en_cnt = 0, ren_cnt = 0, exp_n = 0;
   logic [63:0] last_addr = '0;
   logic [95:0] exp_q[$];
   bit          corrupt = 0;
   logic [31:0] mem [0:511];

   prog_loader #(.IMEM_DEPTH(512), .RUN_W(32)) dut (
      .clk(clk), .arst_n(arst_n), .start(start), .run_cycles(run_cycles),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .rdata_ext(rdata_ext), .cpu_enable(cpu_enable), .busy(busy), .done(done),
      .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wen_ext) mem[addr_ext[10:2]] <= wdata_ext;
      if (ren_ext) rdata_ext <= mem[addr_ext[10:2]] ^ ((corrupt && addr_ext[10:2] == 9'd1) ? 32'h1 : 32'h0);
   end

   always @(negedge clk) if (arst_n) begin
      if (cpu_enable) begin
         en_cnt++;
         checks++;
         if (wen_ext || ren_ext) begin
            errors++;
            $display("FAIL excl: wen=%b ren=%b while cpu_enable=1, need both 0", wen_ext, ren_ext);
         end
      end
      if (ren_ext) ren_cnt++;
      if (wen_ext) begin
         checks++;
         last_addr = addr_ext;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write: unexpected write addr=%h data=%h", addr_ext, wdata_ext);
         end else begin
            logic [95:0] e;
            e = exp_q.pop_front();
            if ({addr_ext, wdata_ext, ren_ext} !== {e, 1'b0}) begin
               errors++;
               $display("FAIL write: got addr=%h data=%h ren=%b, need addr=%h data=%h ren=0",
                        addr_ext, wdata_ext, ren_ext, e[95:32], e[31:0]);
            end
         end
      end
   end

   task automatic pulse_start(input logic [31:0] r);
      run_cycles = r;
      exp_n = 0;
      en_cnt = 0;
      ren_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic last, output bit ok);
      s_valid = 1'b1;
      s_data = d;
      s_last = last;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (s_ready) begin
            exp_q.push_back({64'(exp_n) << 2, d});
            exp_n++;
            ok = 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_end(output bit to);
      to = 1;
      for (int i = 0; i < 100; i++) begin
         if (done || error) begin
            to = 0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if ({s_ready, addr_ext, wen_ext, ren_ext, wdata_ext, cpu_enable, busy, done, error, word_count} !== '0) begin
         errors++;
         $display("FAIL reset: outputs not all zero in reset (wc=%0d addr=%h)", word_count, addr_ext);
      end
      arst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({s_ready, wen_ext, cpu_enable, busy, done, error, word_count} !== '0) begin
         errors++;
         $display("FAIL idle: outputs changed after reset release, busy=%b done=%b", busy, done);
      end
   endtask

   task automatic test_load_run;
      bit ok, all_ok = 1, to;
      int exp_ren;
`ifdef PROG_LOADER_VERIFY_EN
      exp_ren = 3;
`else
      exp_ren = 0;
`endif
      pulse_start(5);
      send_word(32'h0000_0013, 1'b0, ok); all_ok &= ok;
      send_word(32'h0010_0093, 1'b0, ok); all_ok &= ok;
      send_word(32'h0020_8113, 1'b1, ok); all_ok &= ok;
      s_valid = 1'b0;
      s_last = 1'b0;
      checks++;
      if (!all_ok || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_hs: accepted=%b s_ready=%b after last, need 1 and 0", all_ok, s_ready);
      end
`ifndef PROG_LOADER_VERIFY_EN
      checks++;
      if ({wen_ext, cpu_enable} !== 2'b10) begin
         errors++;
         $display("FAIL final_write: wen,cpu_enable=%b need 10", {wen_ext, cpu_enable});
      end
      @(negedge clk);
      checks++;
      if ({wen_ext, cpu_enable} !== 2'b01) begin
         errors++;
         $display("FAIL en_rise: wen,cpu_enable=%b need 01", {wen_ext, cpu_enable});
      end
`endif
      wait_end(to);
      checks++;
      if (to || {done, error, busy} !== 3'b100 || word_count !== 10'd3) begin
         errors++;
         $display("FAIL load_end: timeout=%b done,error,busy=%b wc=%0d, need 0 100 3", to, {done, error, busy}, word_count);
      end
      checks++;
      if (en_cnt != 5 || exp_q.size() != 0 || ren_cnt != exp_ren) begin
         errors++;
         $display("FAIL run_len: en_cycles=%0d pending=%0d reads=%0d, need 5 0 %0d", en_cnt, exp_q.size(), ren_cnt, exp_ren);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_hold: done=%b need 1", done);
      end
   endtask

   task automatic test_back_pressure;
      bit ok, all_ok = 1, to, bad = 0;
      pulse_start(2);
      send_word(32'h1111_0001, 1'b0, ok); all_ok &= ok;
      s_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (wen_ext !== 1'b0) bad = 1;
      end
      send_word(32'h1111_0002, 1'b0, ok); all_ok &= ok;
      send_word(32'h1111_0003, 1'b1, ok); all_ok &= ok;
      s_valid = 1'b0;
      s_last = 1'b0;
      checks++;
      if (!all_ok || bad) begin
         errors++;
         $display("FAIL bp_gap: accepted=%b write_in_gap=%b, need 1 0", all_ok, bad);
      end
      wait_end(to);
      checks++;
      if (to || done !== 1'b1 || word_count !== 10'd3 || en_cnt != 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_end: done=%b wc=%0d en=%0d pending=%0d, need 1 3 2 0", done, word_count, en_cnt, exp_q.size());
      end
   endtask

   task automatic test_overflow;
      bit ok, all_ok = 1, bad = 0;
      pulse_start(3);
      for (int i = 0; i < 512; i++) begin
         send_word(32'hA000_0000 + i, 1'b0, ok);
         all_ok &= ok;
      end
      checks++;
      if (!all_ok || error !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ovf_state: accepted=%b error=%b s_ready=%b busy=%b, need 1 1 0 0", all_ok, error, s_ready, busy);
      end
      s_data = 32'hDEAD_BEEF;
      repeat (5) begin
         @(negedge clk);
         if (s_ready !== 1'b0 || wen_ext !== 1'b0) bad = 1;
      end
      s_valid = 1'b0;
      checks++;
      if (bad || error !== 1'b1) begin
         errors++;
         $display("FAIL ovf_513: extra word taken=%b error=%b, need 0 1", bad, error);
      end
      checks++;
      if (word_count !== 10'd512 || last_addr !== 64'h7FC || en_cnt != 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL ovf_count: wc=%0d last_addr=%h en=%0d pending=%0d, need 512 7fc 0 0", word_count, last_addr, en_cnt, exp_q.size());
      end
   endtask

   task automatic test_zero_run;
      bit ok, to;
      pulse_start(0);
      send_word(32'h0000_0073, 1'b1, ok);
      s_valid = 1'b0;
      s_last = 1'b0;
      wait_end(to);
      repeat (2) @(negedge clk);
      checks++;
      if (!ok || to || {done, error} !== 2'b10 || en_cnt != 0 || word_count !== 10'd1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL zero_run: done,error=%b en=%0d wc=%0d pending=%0d, need 10 0 1 0", {done, error}, en_cnt, word_count, exp_q.size());
      end
   endtask

`ifdef PROG_LOADER_VERIFY_EN
   task automatic test_verify;
      bit ok, all_ok = 1;
      int lat;
      corrupt = 1;
      pulse_start(4);
      for (int i = 0; i < 3; i++) begin
         send_word(32'h5500_0000 + i, i == 2, ok);
         all_ok &= ok;
      end
      s_valid = 1'b0;
      s_last = 1'b0;
      lat = 0;
      while (!error && !cpu_enable && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (!all_ok || error !== 1'b1 || lat != 5 || en_cnt != 0 || ren_cnt != 3) begin
         errors++;
         $display("FAIL vfy_bad: error=%b lat=%0d en=%0d reads=%0d, need 1 5 0 3", error, lat, en_cnt, ren_cnt);
      end
      corrupt = 0;
      pulse_start(4);
      for (int i = 0; i < 3; i++) begin
         send_word(32'h5500_0000 + i, i == 2, ok);
         all_ok &= ok;
      end
      s_valid = 1'b0;
      s_last = 1'b0;
      lat = 0;
      while (!error && !cpu_enable && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (!all_ok || cpu_enable !== 1'b1 || error !== 1'b0 || lat != 5) begin
         errors++;
         $display("FAIL vfy_good: cpu_enable=%b error=%b lat=%0d, need 1 0 5", cpu_enable, error, lat);
      end
      repeat (6) @(negedge clk);
      checks++;
      if (done !== 1'b1 || en_cnt != 4 || ren_cnt != 3) begin
         errors++;
         $display("FAIL vfy_run: done=%b en=%0d reads=%0d, need 1 4 3", done, en_cnt, ren_cnt);
      end
   endtask
`endif

   task automatic test_reset_restart;
      bit ok, to;
      int i;
      pulse_start(20);
      send_word(32'h0000_1111, 1'b0, ok);
      send_word(32'h0000_2222, 1'b1, ok);
      s_valid = 1'b0;
      s_last = 1'b0;
      i = 0;
      while (!cpu_enable && i < 30) begin
         @(negedge clk);
         i++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (cpu_enable !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rr_run: cpu_enable=%b busy=%b, need 1 1", cpu_enable, busy);
      end
      #2 arst_n = 1'b0;
      #1;
      checks++;
      if ({s_ready, addr_ext, wen_ext, ren_ext, wdata_ext, cpu_enable, busy, done, error, word_count} !== '0) begin
         errors++;
         $display("FAIL rr_async: outputs not zero right after reset, cpu_enable=%b busy=%b wc=%0d", cpu_enable, busy, word_count);
      end
      exp_q.delete();
      @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      pulse_start(1);
      send_word(32'h0000_CAFE, 1'b1, ok);
      s_valid = 1'b0;
      s_last = 1'b0;
      wait_end(to);
      checks++;
      if (!ok || to || done !== 1'b1 || word_count !== 10'd1 || last_addr !== 64'h0 || en_cnt != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rr_restart: done=%b wc=%0d last_addr=%h en=%0d, need 1 1 0 1", done, word_count, last_addr, en_cnt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_load_run;
      test_back_pressure;
      test_overflow;
      test_zero_run;
`ifdef PROG_LOADER_VERIFY_EN
      test_verify;
`endif
      test_reset_restart;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
